axil_mem_responder: RTL and testbench

AXI4-Lite responder (slave) giving the PS master port a small word-addressed scratch memory in PL. It completes the write/read-back traffic the MPSoC master issues during bring-up. Word 0 also drives the board LED outputs. It sits behind the PS master AXI interconnect and is exercised by the MPSoC testbench through the PS write/read tasks.

---
 rtl/axil_mem_pkg.sv | 10 +
 rtl/axil_mem_if.sv | 34 +++
 rtl/axil_mem_array.sv | 31 +++
 rtl/axil_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_axil_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_mem_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite scratch memory responder.
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WIdle, WResp} wr_state_e;
  typedef enum logic {RIdle, RData} rd_state_e;

endpackage

// File: rtl/axil_mem_if.sv
// AXI4-Lite channel bundle (32-bit data) with master and slave views.
interface axil_mem_if #(
  parameter int unsigned ADDR_WIDTH = 12
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_mem_array.sv
// Unreset DEPTH_WORDS x 32 storage: one byte-enabled write port, one registered read port.
module axil_mem_array #(
  parameter int unsigned DEPTH_WORDS = 512,
  localparam int unsigned AddrW      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read sees the pre-write contents when both ports hit the same word on one edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-Lite scratch memory responder; word 0 is a reset register that drives LEDS.
// Define AXIL_MEM_SLVERR_EN to reject out-of-range accesses with SLVERR instead of wrapping.
module axil_mem_responder
  import axil_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LED_WIDTH   = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axil_mem_if.slave            s_axil,
  output logic [LED_WIDTH-1:0] LEDS
);

  localparam int unsigned ArrW = $clog2(DEPTH_WORDS);

  wr_state_e             w_state_q, w_state_d;
  logic                  aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           word0_q, word0_d;
  logic                  aw_ready, w_ready, aw_have, w_have, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [ArrW-1:0]       wr_idx;
  logic                  wr_ok, wr_hit;

  rd_state_e             r_state_q, r_state_d;
  logic                  r_arr_q, r_arr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_ready, ar_hs, rd_ok, rd_hit;
  logic [ArrW-1:0]       rd_idx;
  logic [31:0]           arr_rdata;
  logic                  unused_addr;

  // A channel handshaking on the commit edge bypasses its latch.
  assign wr_addr = aw_lat_q ? awaddr_q : s_axil.awaddr;
  assign wr_data = w_lat_q ? wdata_q : s_axil.wdata;
  assign wr_strb = w_lat_q ? wstrb_q : s_axil.wstrb;
  assign wr_idx  = wr_addr[ArrW+1:2];
  assign rd_idx  = s_axil.araddr[ArrW+1:2];

`ifdef AXIL_MEM_SLVERR_EN
  assign wr_ok  = 32'(wr_addr[ADDR_WIDTH-1:2]) < DEPTH_WORDS;
  assign wr_hit = wr_ok;
  assign rd_ok  = 32'(s_axil.araddr[ADDR_WIDTH-1:2]) < DEPTH_WORDS;
  assign rd_hit = rd_ok;
`else
  assign wr_ok  = 1'b1;
  assign wr_hit = 32'(wr_idx) < DEPTH_WORDS;
  assign rd_ok  = 1'b1;
  assign rd_hit = 32'(rd_idx) < DEPTH_WORDS;
`endif

  assign unused_addr = ^{wr_addr, s_axil.araddr};

  always_comb begin
    w_state_d = w_state_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    aw_have   = 1'b0;
    w_have    = 1'b0;
    commit    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        aw_ready = ~aw_lat_q & ~ARESET;
        w_ready  = ~w_lat_q & ~ARESET;
        aw_have  = aw_lat_q | (s_axil.awvalid & aw_ready);
        w_have   = w_lat_q | (s_axil.wvalid & w_ready);
        if (s_axil.awvalid && aw_ready) awaddr_d = s_axil.awaddr;
        if (s_axil.wvalid && w_ready) begin
          wdata_d = s_axil.wdata;
          wstrb_d = s_axil.wstrb;
        end
        if (aw_have && w_have) begin
          commit    = 1'b1;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          w_state_d = WResp;
        end else begin
          aw_lat_d = aw_have;
          w_lat_d  = w_have;
        end
      end
      WResp: if (s_axil.bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    word0_d = word0_q;
    if (commit && wr_hit && (wr_idx == '0)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) word0_d[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_arr_d   = r_arr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_ready  = (r_state_q == RIdle) & ~ARESET;
    ar_hs     = ar_ready & s_axil.arvalid;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RData;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_arr_d   = rd_hit && (rd_idx != '0);
          rdata_d   = (rd_hit && (rd_idx == '0)) ? word0_q : '0;
        end
      end
      RData: if (s_axil.rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= WIdle;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      word0_q   <= '0;
      r_state_q <= RIdle;
      r_arr_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      bresp_q   <= bresp_d;
      word0_q   <= word0_d;
      r_state_q <= r_state_d;
      r_arr_q   <= r_arr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Latched payloads are qualified by the latch flags and need no reset.
  always_ff @(posedge ACLK) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  axil_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (ACLK),
    .we_i    (commit && wr_hit && (wr_idx != '0)),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .re_i    (ar_hs && rd_hit && (rd_idx != '0)),
    .raddr_i (rd_idx),
    .rdata_o (arr_rdata)
  );

  assign s_axil.awready = aw_ready;
  assign s_axil.wready  = w_ready;
  assign s_axil.bvalid  = (w_state_q == WResp);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = ar_ready;
  assign s_axil.rvalid  = (r_state_q == RData);
  assign s_axil.rdata   = r_arr_q ? arr_rdata : rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign LEDS           = word0_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_axil_mem_responder.sv
// Randomized bench for axil_mem_responder against a word-array model of the scratch memory.
module tb_axil_mem_responder;
  import axil_mem_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 512;
  localparam int LW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_mem_if #(.ADDR_WIDTH(AW)) bus ();
  logic [LW-1:0] leds;

  axil_mem_responder #(
    .ADDR_WIDTH  (AW),
    .DEPTH_WORDS (DEPTH),
    .LED_WIDTH   (LW)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axil (bus),
    .LEDS   (leds)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: one word per index, with a flag for words holding defined data.
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } wr_t;

  logic [31:0]   m_mem   [DEPTH];
  bit            m_known [DEPTH];
  wr_t           wr_q [$];
  logic [AW-1:0] rd_q [$];

  function automatic bit m_oob(input logic [AW-1:0] a);
`ifdef AXIL_MEM_SLVERR_EN
    return int'(a[AW-1:2]) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [AW-1:0] a);
    return int'(a[AW-1:2]) % DEPTH;
  endfunction

  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp, exp_bresp;
  bit          exp_rknown;
  bit          rst_prev = 1'b1;
  logic        rv_prev = 1'b0, rr_prev = 1'b0, bv_prev = 1'b0, br_prev = 1'b0;

  always @(negedge clk) begin : monitor
    logic [AW-1:0] a;
    wr_t           w;
    int            i;
    if (rst_prev) begin
      m_mem[0]   = '0;
      m_known[0] = 1'b1;
      wr_q.delete();
      rd_q.delete();
      check("rst_bvalid", 32'(bus.bvalid), 0);
      check("rst_rvalid", 32'(bus.rvalid), 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_resps", 32'({bus.bresp, bus.rresp}), 0);
    end else begin
      // Read capture is evaluated before a write committing on the same edge.
      if (bus.rvalid && !rv_prev) begin
        if (rd_q.size() == 0) check("r_unexpected", 32'(bus.rvalid), 0);
        else begin
          a = rd_q.pop_front();
          if (m_oob(a)) begin
            exp_rdata = '0; exp_rresp = RESP_SLVERR; exp_rknown = 1'b1;
          end else begin
            i = m_idx(a);
            exp_rdata = m_mem[i]; exp_rresp = RESP_OKAY; exp_rknown = m_known[i];
          end
        end
      end
      if (bus.bvalid && !bv_prev) begin
        if (wr_q.size() == 0) check("b_unexpected", 32'(bus.bvalid), 0);
        else begin
          w = wr_q.pop_front();
          if (m_oob(w.addr)) exp_bresp = RESP_SLVERR;
          else begin
            exp_bresp = RESP_OKAY;
            i = m_idx(w.addr);
            for (int b = 0; b < 4; b++) if (w.strb[b]) m_mem[i][8*b +: 8] = w.data[8*b +: 8];
            if (w.strb == 4'hF) m_known[i] = 1'b1;
          end
        end
      end
      if (rv_prev && !rr_prev) check("r_hold", 32'(bus.rvalid), 1);
      if (bv_prev && !br_prev) check("b_hold", 32'(bus.bvalid), 1);
      if (bus.rvalid) begin
        check("rresp", 32'(bus.rresp), 32'(exp_rresp));
        if (exp_rknown) check("rdata", bus.rdata, exp_rdata);
        check("arready_busy", 32'(bus.arready), 0);
      end
      if (bus.bvalid) begin
        check("bresp", 32'(bus.bresp), 32'(exp_bresp));
        check("aw_w_ready_busy", 32'({bus.awready, bus.wready}), 0);
      end
    end
    if (rst) check("rst_readys", 32'({bus.awready, bus.wready, bus.arready}), 0);
    check("leds", 32'(leds), 32'(m_mem[0][LW-1:0]));
    rv_prev  = bus.rvalid;
    rr_prev  = bus.rready;
    bv_prev  = bus.bvalid;
    br_prev  = bus.bready;
    rst_prev = rst;
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp);
    int n;
    wr_q.push_back('{addr: addr, data: data, strb: strb});
    fork
      begin
        int k;
        repeat (aw_dly) @(posedge clk);
        #1 bus.awaddr = addr; bus.awvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.awready && k < 50);
        check("aw_handshake", 32'(bus.awready), 1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) @(posedge clk);
        #1 bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.wready && k < 50);
        check("w_handshake", 32'(bus.wready), 1);
        @(posedge clk); #1 bus.wvalid = 1'b0;
      end
    join
    @(negedge clk);
    check("b_latency", 32'(bus.bvalid), 1);
    repeat (b_dly) @(negedge clk);
    @(posedge clk); #1 bus.bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < 50);
    check("b_handshake", 32'(bus.bvalid), 1);
    resp = bus.bresp;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    repeat (ar_dly) @(posedge clk);
    #1 bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
    check("ar_handshake", 32'(bus.arready), 1);
    rd_q.push_back(addr);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 32'(bus.rvalid), 1);
    repeat (r_dly) @(negedge clk);
    @(posedge clk); #1 bus.rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rvalid && n < 50);
    check("r_handshake", 32'(bus.rvalid), 1);
    data = bus.rdata;
    resp = bus.rresp;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  logic [AW-1:0] addr_tab [9];
  logic [31:0]   rd;
  logic [1:0]    rr, br;

  initial begin
    addr_tab = '{12'h000, 12'h004, 12'h008, 12'h020, 12'h1FC, 12'h7FC, 12'h800, 12'h804, 12'hFFC};
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

    // AW and W together to word 0.
    @(posedge clk);
    axi_write(12'h000, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
    check("t1_bresp", 32'(br), 32'(RESP_OKAY));
    check("t1_leds", 32'(leds), 32'hF);
    axi_read(12'h000, 0, 0, rd, rr);
    check("t1_rdata", rd, 32'hDEADBEEF);

    // W two cycles before AW, then a single-byte update.
    axi_write(12'h010, 32'h12345678, 4'hF, 2, 0, 0, br);
    axi_write(12'h010, 32'h0000AB00, 4'b0010, 0, 1, 0, br);
    axi_read(12'h010, 0, 1, rd, rr);
    check("t2_rdata", rd, 32'h1234AB78);

    // Empty strobe completes without changing data.
    axi_write(12'h010, 32'hFFFFFFFF, 4'h0, 1, 0, 0, br);
    check("strb0_bresp", 32'(br), 32'(RESP_OKAY));
    axi_read(12'h010, 0, 0, rd, rr);
    check("strb0_rdata", rd, 32'h1234AB78);

    // Response held while BREADY stays low.
    axi_write(12'h004, 32'hA5A5A5A5, 4'hF, 0, 0, 5, br);
    check("t3_bresp", 32'(br), 32'(RESP_OKAY));

    // Read on the commit edge sees the old word; the next read sees the new one.
    axi_write(12'h020, 32'h11111111, 4'hF, 0, 0, 0, br);
    fork
      axi_write(12'h020, 32'h55AA55AA, 4'hF, 0, 0, 0, br);
      axi_read(12'h020, 0, 0, rd, rr);
    join
    check("t4_pre_write", rd, 32'h11111111);
    axi_read(12'h020, 0, 0, rd, rr);
    check("t4_post_write", rd, 32'h55AA55AA);

    // Index 512.
    axi_write(12'h800, 32'hCAFE0005, 4'hF, 0, 0, 0, br);
`ifdef AXIL_MEM_SLVERR_EN
    check("oob_bresp", 32'(br), 32'h2);
    axi_read(12'h800, 0, 0, rd, rr);
    check("oob_rdata", rd, 32'h0);
    check("oob_rresp", 32'(rr), 32'h2);
    check("oob_leds", 32'(leds), 32'hF);
`else
    check("wrap_bresp", 32'(br), 32'h0);
    axi_read(12'h000, 0, 0, rd, rr);
    check("wrap_rdata", rd, 32'hCAFE0005);
    check("wrap_leds", 32'(leds), 32'h5);
`endif

    // Random traffic over a small address set (0x010 is left alone).
    foreach (addr_tab[k]) axi_write(addr_tab[k], $urandom, 4'hF, 0, 0, 0, br);
    for (int it = 0; it < 150; it++) begin
      logic [AW-1:0] a, a2;
      logic [31:0]   d;
      logic [3:0]    s;
      a  = addr_tab[$urandom_range(0, 8)];
      a2 = addr_tab[$urandom_range(0, 8)];
      d  = $urandom;
      s  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      case ($urandom_range(0, 2))
        0: axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), br);
        1: axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
        default: fork
          axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), br);
          axi_read(a2, $urandom_range(0, 2), $urandom_range(0, 2), rd, rr);
        join
      endcase
    end

    // Reset while a read response is pending.
    axi_write(12'h000, 32'h0000000F, 4'hF, 0, 0, 0, br);
    check("pre_rst_leds", 32'(leds), 32'hF);
    #1 bus.araddr = 12'h010; bus.arvalid = 1'b1;
    @(negedge clk);
    check("rst_ar_handshake", 32'(bus.arready), 1);
    rd_q.push_back(12'h010);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    check("rst_rvalid_pending", 32'(bus.rvalid), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", 32'(bus.rvalid), 0);
    check("post_rst_leds", 32'(leds), 0);
    check("post_rst_arready", 32'(bus.arready), 1);
    @(posedge clk);
    axi_read(12'h010, 0, 0, rd, rr);
    check("post_rst_keep", rd, 32'h1234AB78);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
